// File: rtl/connect_four_move_ctrl.sv
// Connect-four cursor and drop controller: one button command per frame, column scan, piece write.
// Drop: scan k+1 cycles, write at T+2+k, check_start at T+3+k; presses while busy wait as pending bits.
module connect_four_move_ctrl (
    input  logic       clk_25MHz,
    input  logic       rst,
    input  logic       move_left,
    input  logic       move_right,
    input  logic       drop_piece,
    input  logic       frame_start,
    input  logic       game_over,
    output logic [5:0] rd_addr,
    input  logic [1:0] rd_data,
    output logic       wr_en,
    output logic [5:0] wr_addr,
    output logic [1:0] wr_data,
    output logic [2:0] current_col,
    output logic [1:0] current_player,
    output logic       check_start,
    output logic [5:0] last_addr,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, SCAN, PLACE, NOTIFY} state_t;

    state_t     r_state;
    logic [2:0] r_sync1;    // bit0 left, bit1 right, bit2 drop
    logic [2:0] r_sync2;
    logic [2:0] r_prev;
    logic [1:0] r_arm_cnt;
    logic [2:0] r_pend;
    logic [2:0] r_k;
    logic [2:0] w_edge;

    // Edges are masked until the edge detector has seen real button levels, so a
    // button held through reset release does not look like a fresh press.
    assign w_edge  = r_sync2 & ~r_prev & {3{r_arm_cnt == 2'd3}};
    assign rd_addr = (r_state == SCAN) ? {r_k, current_col} : {3'b000, current_col};

    always_ff @(posedge clk_25MHz) begin
        if (rst) begin
            r_state        <= IDLE;
            r_sync1        <= 3'b000;
            r_sync2        <= 3'b000;
            r_prev         <= 3'b000;
            r_arm_cnt      <= 2'd0;
            r_pend         <= 3'b000;
            r_k            <= 3'd0;
            current_col    <= 3'd3;
            current_player <= 2'b01;
            wr_en          <= 1'b0;
            wr_addr        <= 6'd0;
            wr_data        <= 2'b00;
            check_start    <= 1'b0;
            last_addr      <= 6'd0;
            busy           <= 1'b0;
        end else begin
            r_sync1 <= {drop_piece, move_right, move_left};
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            if (r_arm_cnt != 2'd3) begin
                r_arm_cnt <= r_arm_cnt + 2'd1;
            end
            wr_en       <= 1'b0;
            check_start <= 1'b0;
            r_pend      <= r_pend | w_edge;

            case (r_state)
                IDLE: begin
                    if (game_over) begin
                        r_pend <= 3'b000;
                    end else if (frame_start) begin
                        if (r_pend[2]) begin
                            r_pend  <= (r_pend & 3'b011) | w_edge;
                            r_k     <= 3'd0;
                            r_state <= SCAN;
                            busy    <= 1'b1;
                        end else if (r_pend[0] && r_pend[1]) begin
                            r_pend <= w_edge;
                        end else if (r_pend[0]) begin
                            r_pend      <= (r_pend & 3'b110) | w_edge;
                            current_col <= current_col - 3'd1;
                        end else if (r_pend[1]) begin
                            r_pend      <= (r_pend & 3'b101) | w_edge;
                            current_col <= current_col + 3'd1;
                        end
                    end
                end
                SCAN: begin
                    if (game_over) begin
                        r_state <= IDLE;
                        busy    <= 1'b0;
                        r_k     <= 3'd0;
                    end else if (rd_data == 2'b00) begin
                        wr_addr <= rd_addr;
                        wr_data <= current_player;
                        wr_en   <= 1'b1;
                        r_state <= PLACE;
                    end else if (r_k == 3'd7) begin
                        r_state <= IDLE;
                        busy    <= 1'b0;
                        r_k     <= 3'd0;
                    end else begin
                        r_k <= r_k + 3'd1;
                    end
                end
                PLACE: begin
                    check_start    <= 1'b1;
                    last_addr      <= wr_addr;
                    current_player <= ~current_player;
                    r_k            <= 3'd0;
                    r_state        <= NOTIFY;
                end
                NOTIFY: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/connect_four_move_ctrl.md
CONNECT_FOUR_MOVE_CTRL -- requirements
Module: connect_four_move_ctrl

Interface
REQ-001 SHALL have no parameters; board is fixed at 8 rows x 8 cols, with cell index = row*8 + col and row 0 as the bottom row.
REQ-002 clk_25MHz  in  1  sole clock; all state updates on its rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 move_left, move_right, drop_piece  in  1 each  raw asynchronous button levels.
REQ-005 frame_start  in  1  one-cycle pulse at start of vertical blank, from the VGA timing.
REQ-006 game_over  in  1  level from the win checker.
REQ-007 rd_addr  out  6  board read address; rd_data  in  2  combinational read data, valid the same cycle.
REQ-008 wr_en  out  1, wr_addr  out  6, wr_data  out  2  board write port; write occurs on the cycle wr_en is high.
REQ-009 current_col  out  3  cursor column.
REQ-010 current_player  out  2  player to move: 01 = player 1, 10 = player 2.
REQ-011 check_start  out  1  one-cycle pulse requesting a win check at last_addr; last_addr  out  6  address of the last placed piece.
REQ-012 busy  out  1  high whenever state is not IDLE.

Function
REQ-013 Each button SHALL pass through a 2-flop synchronizer followed by a rising-edge detector; a detected edge sets that button's pending bit.
REQ-014 Pending bits SHALL be sampled only when frame_start=1 and state=IDLE, so at most one command executes per frame.
REQ-015 Command priority: drop > left > right; the serviced bit clears, others persist.
REQ-016 If left and right are both pending and drop is not, both bits SHALL clear and the cursor SHALL not move.
REQ-017 Left: current_col decrements, 0 wraps to 7; right: increments, 7 wraps to 0; the update is visible the cycle after frame_start.
REQ-018 FSM states: IDLE, SCAN, PLACE, NOTIFY.
REQ-019 IDLE->SCAN on frame_start with a serviced drop; the scan row counter k = 0.
REQ-020 In SCAN, rd_addr SHALL equal k*8 + current_col.
REQ-021 In SCAN, if rd_data==00 -> PLACE with wr_addr latched.
REQ-022 In SCAN, else if k==7 (column full) -> IDLE with no write and no player change.
REQ-023 In SCAN, otherwise k increments and the FSM stays in SCAN.
REQ-024 PLACE lasts one cycle: wr_en=1, wr_data=current_player; -> NOTIFY.
REQ-025 NOTIFY lasts one cycle: check_start=1, last_addr=wr_addr, current_player toggles 01<->10; -> IDLE.
REQ-026 Latency: with frame_start at cycle T and the first empty row k, SCAN runs T+1..T+1+k, wr_en is at T+2+k, and check_start is at T+3+k.
REQ-027 current_col SHALL not change while busy=1; left/right edges arriving while busy set pending bits only.
REQ-028 game_over=1 in IDLE: all pending bits clear every cycle and no command executes.
REQ-029 game_over rising during SCAN: the scan aborts to IDLE with no write.
REQ-030 game_over rising during PLACE or NOTIFY: that sequence completes.
REQ-031 wr_en and check_start SHALL never both be high in one cycle; wr_en is at most one cycle per drop.
REQ-032 Outputs SHALL be registered except rd_addr, which is combinational from state/k/current_col.
REQ-033 Outside SCAN, rd_addr SHALL equal current_col.

Reset
REQ-034 On rst=1 at a clock edge: state=IDLE, current_col=3, current_player=01, pending and synchronizer flops=0, wr_en=0, check_start=0, wr_addr=0, last_addr=0, busy=0, k=0.
REQ-035 rst mid-SCAN or mid-PLACE SHALL abandon the sequence; no wr_en is asserted in the cycle after rst.
REQ-036 A button held high through reset release SHALL not generate an edge until released and pressed again.

Verification
REQ-037 Empty board, col 3, pulse drop, then frame_start at T -> rd_addr=3 at T+1, wr_en at T+2 with wr_addr=3, wr_data=01, check_start at T+3, current_player=10 after.
REQ-038 Column 3 rows 0-2 occupied, drop -> SCAN rd_addr 3,11,19,27; wr_addr=27 at T+5; check_start at T+6.
REQ-039 Column 5 full, drop -> 8 SCAN cycles, no wr_en, current_player unchanged, busy low at T+9.
REQ-040 Wrap cases: col 0 + left + frame_start -> col 7; then right + frame_start -> col 0; left and right together -> col unchanged, both cleared.
REQ-041 Drop and left both pending at one frame_start -> drop executes; next frame_start moves left.
REQ-042 game_over asserted at T+2 of a scan reaching row 4 -> no wr_en, busy low at T+3; pending left is cleared and ignored on the following frame.
